// File: rtl/wisc_pipe_pkg.sv
// rtl/wisc_pipe_pkg.sv - shared pipeline widths and skid-buffer state encoding
//
// Purpose : default datapath widths and the FSM state type shared by the
//           EX->MEM result skid buffer and its entry registers.
// Ports   : none (package).
package wisc_pipe_pkg;

  localparam int ALU_RESULT_W = 16;
  localparam int ALU_DEST_W   = 3;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_FULL  = 2'b10
  } skid_state_e;

endpackage

// File: rtl/pipe_entry_reg.sv
// rtl/pipe_entry_reg.sv - load-enabled pipeline entry register with async reset
//
// Purpose : holds one packed pipeline entry; loads d when ld is high.
// Ports   : clk   - rising-edge clock
//           rst_n - asynchronous active-low reset, clears the entry to 0
//           ld    - load enable
//           d     - next entry value
//           q     - held entry
module pipe_entry_reg #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] data_q;
  logic [W-1:0] data_d;

  always_comb begin
    data_d = data_q;
    if (ld) begin
      data_d = d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign q = data_q;

endmodule

// File: rtl/alu_result_skid.sv
// rtl/alu_result_skid.sv - 2-entry skid buffer between the EX and MEM stages
//
// Purpose : decouples the ALU result handshake from MEM backpressure. The main
//           register is the head and drives out_*; the skid register catches
//           one extra result so in_ready never depends on out_ready.
//           Optional feature macro: ALU_SKID_ZERO_FLAG_EN adds out_zero, a
//           per-entry flag of (in_result == 0) captured at push.
// Ports   : clk, rst_n             - clock, asynchronous active-low reset
//           in_valid/in_ready      - EX-side handshake
//           in_result/in_dest/in_wr- EX result word, destination, write enable
//           flush                  - discard all held entries
//           out_valid/out_ready    - MEM-side handshake
//           out_result/out_dest/out_wr - head entry
//           out_zero               - head entry zero flag (macro only)
module alu_result_skid
  import wisc_pipe_pkg::*;
#(
  parameter int WIDTH  = ALU_RESULT_W,
  parameter int DEST_W = ALU_DEST_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_result,
  input  logic [DEST_W-1:0] in_dest,
  input  logic              in_wr,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH-1:0]  out_result,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_wr
`ifdef ALU_SKID_ZERO_FLAG_EN
  ,
  output logic              out_zero
`endif
);

  // Entry layout, LSB first: result, dest, wr, then the optional zero flag.
`ifdef ALU_SKID_ZERO_FLAG_EN
  localparam int ENTRY_W = WIDTH + DEST_W + 2;
`else
  localparam int ENTRY_W = WIDTH + DEST_W + 1;
`endif

  skid_state_e        state_q;
  skid_state_e        state_d;
  logic [ENTRY_W-1:0] in_entry;
  logic [ENTRY_W-1:0] main_q;
  logic [ENTRY_W-1:0] main_nx;
  logic [ENTRY_W-1:0] skid_q;
  logic [ENTRY_W-1:0] skid_nx;
  logic               main_ld;
  logic               skid_ld;
  logic               push;
  logic               pop;

`ifdef ALU_SKID_ZERO_FLAG_EN
  assign in_entry = {(in_result == '0), in_wr, in_dest, in_result};
`else
  assign in_entry = {in_wr, in_dest, in_result};
`endif

  // Handshake flags come only from the state register.
  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Any entry that becomes invalid is reloaded with zero so stale data never
  // sits in the registers.
  always_comb begin
    state_d = state_q;
    main_ld = 1'b0;
    main_nx = in_entry;
    skid_ld = 1'b0;
    skid_nx = '0;
    if (flush) begin
      state_d = ST_EMPTY;
      main_ld = 1'b1;
      main_nx = '0;
      skid_ld = 1'b1;
    end else begin
      unique case (state_q)
        ST_EMPTY: begin
          if (push) begin
            main_ld = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (push && pop) begin
            main_ld = 1'b1;
          end else if (push) begin
            skid_ld = 1'b1;
            skid_nx = in_entry;
            state_d = ST_FULL;
          end else if (pop) begin
            main_ld = 1'b1;
            main_nx = '0;
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only a pop can happen.
          if (pop) begin
            main_ld = 1'b1;
            main_nx = skid_q;
            skid_ld = 1'b1;
            state_d = ST_ONE;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          main_ld = 1'b1;
          main_nx = '0;
          skid_ld = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  pipe_entry_reg #(.W(ENTRY_W)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (main_ld),
    .d     (main_nx),
    .q     (main_q)
  );

  pipe_entry_reg #(.W(ENTRY_W)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (skid_ld),
    .d     (skid_nx),
    .q     (skid_q)
  );

  assign out_result = main_q[WIDTH-1:0];
  assign out_dest   = main_q[WIDTH +: DEST_W];
  assign out_wr     = main_q[WIDTH+DEST_W];
`ifdef ALU_SKID_ZERO_FLAG_EN
  assign out_zero   = main_q[WIDTH+DEST_W+1];
`endif

endmodule

// File: tb/tb_alu_result_skid.sv
// tb/tb_alu_result_skid.sv - scoreboard testbench for alu_result_skid
module tb_alu_result_skid;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_result;
  logic [2:0]  in_dest;
  logic        in_wr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_result;
  logic [2:0]  out_dest;
  logic        out_wr;
`ifdef ALU_SKID_ZERO_FLAG_EN
  logic        out_zero;
`endif

  int checks = 0;
  int errors = 0;
  logic [19:0] sb_q[$];
  int pops_seen = 0;

  alu_result_skid #(.WIDTH(16), .DEST_W(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_dest    (in_dest),
    .in_wr      (in_wr),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_dest   (out_dest),
    .out_wr     (out_wr)
`ifdef ALU_SKID_ZERO_FLAG_EN
    ,
    .out_zero   (out_zero)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: evaluated mid-cycle, predicts the coming edge from the
  // current inputs and compares the head against the expected queue.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_result", 32'(out_result), 32'd0);
    end else begin
      check("out_valid", 32'(out_valid), 32'(sb_q.size() != 0));
      check("in_ready", 32'(in_ready), 32'(sb_q.size() < 2));
      if (sb_q.size() != 0) begin
        check("out_result", 32'(out_result), 32'(sb_q[0][15:0]));
        check("out_dest", 32'(out_dest), 32'(sb_q[0][18:16]));
        check("out_wr", 32'(out_wr), 32'(sb_q[0][19]));
`ifdef ALU_SKID_ZERO_FLAG_EN
        check("out_zero", 32'(out_zero), 32'(sb_q[0][15:0] == 16'h0));
`endif
      end else begin
        check("idle_zero_data", 32'({out_wr, out_dest, out_result}), 32'd0);
      end
      if (flush) begin
        sb_q.delete();
      end else begin
        if (out_valid && out_ready && sb_q.size() != 0) begin
          void'(sb_q.pop_front());
          pops_seen++;
        end
        if (in_valid && in_ready) begin
          sb_q.push_back({in_wr, in_dest, in_result});
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [15:0] r, input logic [2:0] d,
                     input logic w, input logic ordy, input logic fl);
    in_valid  = v;
    in_result = r;
    in_dest   = d;
    in_wr     = w;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic ordy);
    cyc(1'b0, 16'h0, 3'd0, 1'b0, ordy, 1'b0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_result = '0;
    in_dest   = '0;
    in_wr     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single push, one-cycle latency, drains the following cycle.
    cyc(1'b1, 16'h00FF, 3'd3, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Fill under backpressure, then drain in order.
    cyc(1'b1, 16'h1111, 3'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h2222, 3'd2, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Back-to-back streaming at full rate.
    for (int i = 1; i <= 16; i++) begin
      cyc(1'b1, 16'(i), 3'(i), 1'(i), 1'b1, 1'b0);
    end
    idle(1'b1);
    idle(1'b1);

    // Flush while FULL with a coinciding push that must be discarded.
    cyc(1'b1, 16'hAAAA, 3'd4, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'hBBBB, 3'd5, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h3333, 3'd6, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Zero-flag ordering pattern.
    cyc(1'b1, 16'h0000, 3'd7, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h8000, 3'd0, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b1);

    // Asynchronous reset mid-cycle while FULL.
    cyc(1'b1, 16'h4444, 3'd1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 16'h5555, 3'd2, 1'b1, 1'b0, 1'b0);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", 32'(out_valid), 32'd0);
    check("async_rst_in_ready", 32'(in_ready), 32'd1);
    check("async_rst_result", 32'(out_result), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b1, 16'h6666, 3'd3, 1'b0, 1'b1, 1'b0);
    idle(1'b1);
    idle(1'b1);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom), 1'($urandom),
          1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 19) == 0));
    end
    repeat (4) idle(1'b1);

    check("drained", 32'(sb_q.size()), 32'd0);
    check("pops_nonzero", 32'(pops_seen > 20), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
